copy_stage_n: RTL

- Clocked, parametrised successor to the self-timed two-way copy stage in the DDP COPY stage.
- Accepts one token and emits it 1 to 2^CNT_W times on the output channel, each copy tagged with its index.
- A token with exb=0 is absorbed and produces no output.
- Sits between the matching/firing stage and the COPY-stage merge.
- Send/Ack handshake semantics are kept but made synchronous (valid/ready), with full throughput on back-to-back tokens.

---
 rtl/copy_stage_n_if.sv | 45 ++++
 rtl/copy_stage_n.sv | 134 +++++++++++++
 2 files changed

// File: rtl/copy_stage_n_if.sv
// ---------------------------------------------------------------------------
// copy_stage_n_if
// Token channel bundle for the clocked copy stage.
//   Upstream side  : Send_in / Ack_out handshake carrying Data_in, Cnt_in,
//                    exb (emit enable) and cpy (copy enable).
//   Downstream side: Send_out / Ack_in handshake carrying Data_out, Idx_out
//                    and Last_out.
//   Status         : CP (token-taken pulse), feb (busy).
// Modports:
//   slave  - the copy stage itself.
//   master - the environment: upstream producer and downstream consumer.
// ---------------------------------------------------------------------------
interface copy_stage_n_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 3
);
    // Upstream channel
    logic              Send_in;
    logic              Ack_out;
    logic [DATA_W-1:0] Data_in;
    logic [CNT_W-1:0]  Cnt_in;
    logic              exb;
    logic              cpy;

    // Downstream channel
    logic              Send_out;
    logic              Ack_in;
    logic [DATA_W-1:0] Data_out;
    logic [CNT_W-1:0]  Idx_out;
    logic              Last_out;

    // Status
    logic              CP;
    logic              feb;

    modport slave (
        input  Send_in, Data_in, Cnt_in, exb, cpy, Ack_in,
        output Ack_out, Send_out, Data_out, Idx_out, Last_out, CP, feb
    );

    modport master (
        output Send_in, Data_in, Cnt_in, exb, cpy, Ack_in,
        input  Ack_out, Send_out, Data_out, Idx_out, Last_out, CP, feb
    );
endinterface

// File: rtl/copy_stage_n.sv
// ---------------------------------------------------------------------------
// copy_stage_n
// Takes one token and emits it Cnt_in+1 times (or once when cpy=0), each
// copy tagged with its 0-based index. Tokens with exb=0 are consumed and
// produce no output. A new token is loaded in the same cycle the final copy
// of the previous one transfers, so back-to-back tokens see no bubble.
//
// Ports:
//   CLK   - clock, all state changes on the rising edge
//   MR_n  - master reset, asynchronous, active-low
//   bus   - copy_stage_n_if.slave:
//             Send_in/Ack_out  upstream handshake (Ack_out combinational)
//             Data_in, Cnt_in, exb, cpy  token fields, sampled on a take
//             Send_out/Ack_in  downstream handshake (Send_out registered)
//             Data_out, Idx_out, Last_out  current copy, registered
//             CP   one-cycle pulse after each take
//             feb  busy while a token is held
// ---------------------------------------------------------------------------
module copy_stage_n #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 3
) (
    input  logic           CLK,
    input  logic           MR_n,
    copy_stage_n_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t            state_q, state_nxt;
    logic [DATA_W-1:0] data_q, data_nxt;
    logic [CNT_W-1:0]  idx_q, idx_nxt;
    logic [CNT_W-1:0]  rem_q, rem_nxt;     // copies still to emit after the current one
    logic              last_q, last_nxt;
    logic              cp_q;

    logic              take;
    logic              load;
    logic [CNT_W-1:0]  load_rem;

    // Ready when empty, or when the final copy is leaving this very cycle.
    // The Ack_in -> Ack_out path is deliberately combinational: it lets the
    // next token be loaded on the edge the last copy transfers.
    assign bus.Ack_out = MR_n & ((state_q == IDLE) |
                                 ((state_q == EMIT) & bus.Ack_in & last_q));

    assign take     = bus.Send_in & bus.Ack_out;
    assign load_rem = bus.cpy ? bus.Cnt_in : '0;

    // -----------------------------------------------------------------------
    // Next-state / next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first so that no path
        // through the case leaves it unassigned, which would infer a latch.
        state_nxt = state_q;
        data_nxt  = data_q;
        idx_nxt   = idx_q;
        rem_nxt   = rem_q;
        last_nxt  = last_q;
        load      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // exb=0 tokens are simply consumed; only CP records them.
                load = take & bus.exb;
            end

            EMIT: begin
                if (bus.Ack_in) begin
                    if (rem_q != '0) begin
                        // Another copy of the same token; payload is held.
                        idx_nxt  = idx_q + 1'b1;
                        rem_nxt  = rem_q - 1'b1;
                        last_nxt = (rem_q == CNT_W'(1));
                    end else if (take && bus.exb) begin
                        load = 1'b1;
                    end else begin
                        // Final copy leaves with nothing to replace it, or the
                        // replacement is an absorbed token.
                        state_nxt = IDLE;
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase

        if (load) begin
            state_nxt = EMIT;
            data_nxt  = bus.Data_in;
            idx_nxt   = '0;
            rem_nxt   = load_rem;
            last_nxt  = (load_rem == '0);
        end
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    // NOTE: the payload register is reset along with the control state so the
    // outputs read a defined zero straight out of reset.
    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
            last_q  <= 1'b0;
            cp_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order.
            state_q <= state_nxt;
            data_q  <= data_nxt;
            idx_q   <= idx_nxt;
            rem_q   <= rem_nxt;
            last_q  <= last_nxt;
            cp_q    <= take;
        end
    end

    // All outputs come straight from flops (state is a single flop bit).
    assign bus.Send_out = (state_q == EMIT);
    assign bus.feb      = (state_q == EMIT);
    assign bus.Data_out = data_q;
    assign bus.Idx_out  = idx_q;
    assign bus.Last_out = last_q;
    assign bus.CP       = cp_q;

endmodule
